// File: rtl/chunk_serial_adder.sv
// chunk_serial_adder
//   Multi-cycle adder: {cout,sum} = a + b + cin, processed CHUNK bits per
//   clock, least significant chunk first, through one CHUNK-bit ripple stage.
//   An accepted start captures the operands, so later changes to a, b or cin
//   do not affect the operation in flight.
//
// Optional feature (macro ADDER_SUB_EN):
//   Adds the 'sub' port. When sub=1 the block computes a - b - cin as
//   a + ~b + ~cin. Here cout=1 means no borrow, and ovf is the signed
//   overflow of the subtraction.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request; sampled only in IDLE or DONE
//   a, b   in   WIDTH-bit operands, captured on an accepted start
//   cin    in   carry-in, captured on an accepted start
//   sub    in   subtract select (ADDER_SUB_EN only)
//   busy   out  high while chunks are being processed
//   done   out  one-cycle completion pulse
//   sum    out  result; updates only at completion
//   cout   out  carry out of the MSB
//   ovf    out  signed (two's-complement) overflow
module chunk_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [CHUNK-1:0]   chunk_a;
  logic [CHUNK-1:0]   chunk_b;
  logic [CHUNK:0]     chunk_ext;
  logic               carry_into_msb;
  logic               last_chunk;
  logic [WIDTH-1:0]   b_load;
  logic               cin_load;

  // Operand conditioning at capture time. For subtraction B and carry-in are
  // stored inverted, so the ripple stage itself is always a plain adder.
  always_comb begin
`ifdef ADDER_SUB_EN
    b_load   = sub ? ~b : b;
    cin_load = sub ? ~cin : cin;
`else
    b_load   = b;
    cin_load = cin;
`endif
  end

  // Chunk datapath: pick the current chunk, add it with the running carry.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        chunk_a = a_q[i*CHUNK +: CHUNK];
        chunk_b = b_q[i*CHUNK +: CHUNK];
      end
    end
    chunk_ext      = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
    // The sum bit at the MSB is a ^ b ^ c_in, so the carry into the MSB
    // can be recovered from the three of them.
    carry_into_msb = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_ext[CHUNK-1];
    last_chunk     = (idx_q == IDX_W'(NCHUNK - 1));
  end

  // Next-state and register update logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b_load;
          carry_d = cin_load;
          idx_d   = '0;
          work_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        for (int unsigned i = 0; i < NCHUNK; i++) begin
          if (idx_q == IDX_W'(i)) begin
            work_d[i*CHUNK +: CHUNK] = chunk_ext[CHUNK-1:0];
          end
        end
        carry_d = chunk_ext[CHUNK];
        idx_d   = idx_q + IDX_W'(1);
        if (last_chunk) begin
          state_d = S_DONE;
          idx_d   = '0;
          sum_d   = work_d;
          cout_d  = chunk_ext[CHUNK];
          ovf_d   = carry_into_msb ^ chunk_ext[CHUNK];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Testbench for chunk_serial_adder (WIDTH=16, CHUNK=4). Compares the design
// against an arithmetic reference model. The subtract cases are compiled in
// only when ADDER_SUB_EN is defined.
module tb_chunk_serial_adder;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int n_checks = 0;
  int n_fail   = 0;

  chunk_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic c, input logic s);
    logic [WIDTH-1:0] yy;
    logic             cc;
    logic [WIDTH:0]   full;
    logic             v;
    yy   = s ? ~y : y;
    cc   = s ? ~c : c;
    full = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, cc};
    v    = (x[WIDTH-1] == yy[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    return {v, full};
  endfunction

  // Stimulus only: present operands and start at a falling edge.
  task automatic drive_start(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                             input logic c, input logic s);
    @(negedge clk);
    a = x; b = y; cin = c; sub = s; start = 1'b1;
  endtask

  // Bounded wait for done; sampled 1 time unit after each rising edge.
  task automatic wait_done(output int cycles, output bit seen);
    seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
  endtask

  // Full cycle-by-cycle timing and result check on the listed vectors.
  task automatic test_add_vectors;
    logic [WIDTH-1:0] va [3] = '{16'h000B, 16'hFFFF, 16'h7FFF};
    logic [WIDTH-1:0] vb [3] = '{16'h0003, 16'h0001, 16'h0000};
    logic             vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [WIDTH+1:0] exp;
    for (int v = 0; v < 3; v++) begin
      exp = model(va[v], vb[v], vc[v], 1'b0);
      drive_start(va[v], vb[v], vc[v], 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      a = '1; b = '1; cin = 1'b1;  // operand changes after acceptance must not matter
      for (int k = 0; k < NCHUNK; k++) begin
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL vec%0d_run_cycle%0d: got busy=%b done=%b, want busy=1 done=0",
                   v, k, busy, done);
        end
        @(posedge clk); #1;
      end
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d_done_pulse: got busy=%b done=%b, want busy=0 done=1", v, busy, done);
      end
      n_checks++;
      if ({ovf, cout, sum} !== exp) begin
        n_fail++;
        $display("FAIL vec%0d_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                 v, sum, cout, ovf, exp[WIDTH-1:0], exp[WIDTH], exp[WIDTH+1]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d_after_done: got busy=%b done=%b, want 0 0", v, busy, done);
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [WIDTH+1:0] exp;
    int cyc;
    bit seen;
    exp = model(16'h1357, 16'h2468, 1'b1, 1'b0);
    drive_start(16'h1357, 16'h2468, 1'b1, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);               // second RUN cycle
    a = 16'h0F0F; b = 16'h7777; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, seen);
    n_checks++;
    if (!seen || cyc != 2) begin
      n_fail++;
      $display("FAIL ignore_done_timing: got seen=%b cycles=%0d, want seen=1 cycles=2", seen, cyc);
    end
    n_checks++;
    if ({ovf, cout, sum} !== exp) begin
      n_fail++;
      $display("FAIL ignore_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
               sum, cout, ovf, exp[WIDTH-1:0], exp[WIDTH], exp[WIDTH+1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int t_first, t_second, t;
    bit ok1, ok2;
    ok1 = 0; ok2 = 0; t_first = 0; t_second = 0; t = 0;
    drive_start(16'h0001, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;           // first accepted
    a = 16'h1234; b = 16'h1111;   // start stays high throughout
    for (int i = 0; i < 30 && !ok2; i++) begin
      @(posedge clk); #1;
      t++;
      if (done === 1'b1 && !ok1) begin
        ok1 = 1'b1; t_first = t;
        n_checks++;
        if (sum !== 16'h0002) begin
          n_fail++;
          $display("FAIL b2b_first_sum: got %h, want 0002", sum);
        end
      end else if (done === 1'b1 && ok1) begin
        ok2 = 1'b1; t_second = t;
        start = 1'b0;
      end else if (ok1 && busy === 1'b1) begin
        n_checks++;
        if (sum !== 16'h0002) begin
          n_fail++;
          $display("FAIL b2b_hold_sum: got %h, want 0002 while second op runs", sum);
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (!ok2 || (t_second - t_first) != NCHUNK + 1) begin
      n_fail++;
      $display("FAIL b2b_spacing: got seen2=%b spacing=%0d, want 1 and %0d",
               ok2, t_second - t_first, NCHUNK + 1);
    end
    n_checks++;
    if (sum !== 16'h2345 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_sum: got sum=%h cout=%b, want 2345 0", sum, cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    bit saw_done;
    int cyc;
    bit seen;
    drive_start(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(posedge clk); #1;           // E0
    start = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);               // third RUN cycle
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL midreset_no_done: got a done pulse, want none");
    end
    drive_start(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, seen);
    n_checks++;
    if (!seen || sum !== 16'hFFFF || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_restart: got seen=%b sum=%h cout=%b, want 1 FFFF 0", seen, sum, cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] x, y;
    logic c, s;
    logic [WIDTH+1:0] exp;
    int cyc;
    bit seen;
    for (int i = 0; i < 25; i++) begin
      x = WIDTH'($urandom);
      y = WIDTH'($urandom);
      c = 1'($urandom);
`ifdef ADDER_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      exp = model(x, y, c, s);
      drive_start(x, y, c, s);
      @(posedge clk); #1;
      start = 1'b0;
      a = ~x; b = ~y; cin = ~c; sub = ~s;
      wait_done(cyc, seen);
      n_checks++;
      if (!seen || cyc != NCHUNK || {ovf, cout, sum} !== exp) begin
        n_fail++;
        $display("FAIL random%0d: a=%h b=%h cin=%b sub=%b got seen=%b cyc=%0d sum=%h cout=%b ovf=%b, want cyc=%0d sum=%h cout=%b ovf=%b",
                 i, x, y, c, s, seen, cyc, sum, cout, ovf, NCHUNK,
                 exp[WIDTH-1:0], exp[WIDTH], exp[WIDTH+1]);
      end
      if ($urandom_range(1, 0) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

`ifdef ADDER_SUB_EN
  task automatic test_sub;
    logic [WIDTH-1:0] va [2] = '{16'h0005, 16'h8000};
    logic [WIDTH-1:0] vb [2] = '{16'h0007, 16'h0001};
    logic [WIDTH+1:0] want [2] = '{{1'b0, 1'b0, 16'hFFFE}, {1'b1, 1'b1, 16'h7FFF}};
    int cyc;
    bit seen;
    for (int v = 0; v < 2; v++) begin
      drive_start(va[v], vb[v], 1'b0, 1'b1);
      @(posedge clk); #1;
      start = 1'b0;
      sub = 1'b0;
      wait_done(cyc, seen);
      n_checks++;
      if (!seen || {ovf, cout, sum} !== want[v]) begin
        n_fail++;
        $display("FAIL sub%0d: got seen=%b sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                 v, seen, sum, cout, ovf, want[v][WIDTH-1:0], want[v][WIDTH], want[v][WIDTH+1]);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_add_vectors;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    test_random;
`ifdef ADDER_SUB_EN
    test_sub;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
